lsu_dmem_master: RTL and testbench
==================================

# lsu_dmem_master

Load/store unit that acts as the initiator on the DMEM port (ena, R, W, 11-bit word address, 32-bit write/read data; asynchronous read, write on posedge). It sits between the CPU datapath and DMEM. It turns byte/halfword/word load and store requests into DMEM cycles. Sub-word stores use a read-modify-write sequence, and load data is sign- or zero-extended. A valid/ready request and a one-cycle response pulse replace the old single-cycle combinational hookup.

## Interface
- ADDR_W, 11, width of the DMEM word index; index = req_addr[ADDR_W+1:2]
- clk  in  1  clock; same clock as DMEM
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  CPU request present
- req_ready  out  1  high only in IDLE; request accepted on posedge when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse, request complete
- resp_rdata  out  32  extended load data; valid while resp_valid, 0 for stores/errors
- resp_err  out  1  misaligned/illegal request; valid while resp_valid
- dmem_ena, dmem_R, dmem_W  out  1 each  DMEM controls
- dmem_addr  out  32  {zeros, word index}
- dmem_in_data  out  32  DMEM write data
- dmem_out_data  in  32  DMEM read data; sampled only in READ

## Operation
- States: IDLE, READ, WRITE, RESP.
- On acceptance, the unit registers we, size, unsigned, addr, and wdata.
- Load: IDLE -> READ -> RESP -> IDLE.
- Store word: IDLE -> WRITE -> RESP.
- Store byte/half: IDLE -> READ -> WRITE -> RESP.
- Error (see Configuration): IDLE -> RESP with resp_err=1. No DMEM access.
- READ drives dmem_ena=1, dmem_R=1, dmem_W=0, dmem_addr=index. dmem_out_data is registered into rd_buf at the end of the cycle.
- WRITE drives dmem_ena=1, dmem_R=0, dmem_W=1, dmem_in_data=merged word.
- Word store: merged = wdata.
- Byte store: rd_buf with lane addr[1:0] replaced by wdata[7:0]; lane k = bits [8k+7:8k], little-endian.
- Half store: lane addr[1] (bits [16h+15:16h]) replaced by wdata[15:0].
- Load extraction: byte lane addr[1:0] or half lane addr[1], then extended per req_unsigned. Word loads return rd_buf unchanged.
- In IDLE and RESP all DMEM outputs are 0 (ena/R/W low, addr 0, data 0).
- req_valid held high during RESP is not accepted until IDLE. Minimum spacing is one request per 3 cycles (load), 3 (SW), or 4 (SB/SH).

## Timing
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
- The DMEM write commits on the posedge ending the WRITE cycle.
- resp_rdata is registered and is stable for the entire RESP cycle.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all dmem_* outputs 0, rd_buf=0.
- Reset mid-operation: outputs drop immediately (asynchronously). A WRITE interrupted by reset before its posedge does not commit. No response is issued for the aborted request.
- Address bits above ADDR_W+1 are ignored, so indices wrap modulo 2^ADDR_W.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - req_size=11, half with addr[0]=1, or word with addr[1:0]!=0 -> error path, resp_err=1, no DMEM cycle.
- LSU_MISALIGN_TRAP_EN undefined:
  - the unit forces addr[0]=0 for half and addr[1:0]=00 for word, and the access proceeds.
  - size 11 is treated as word.
  - resp_err is tied 0.

## Test plan
- DMEM[4]=0x8899AABB; load byte signed at addr 0x11 -> resp_rdata=0xFFFFFFAA, 2 cycles after accept; same access unsigned -> 0x000000AA.
- Load half signed at addr 0x12 with DMEM[4]=0x8899AABB -> 0xFFFF8899; load word at 0x10 -> 0x8899AABB.
- SB 0x5A to addr 0x13 with DMEM[4]=0x11223344 -> one READ then one WRITE of 0x5A223344; resp_valid 3 cycles after accept.
- SW 0xDEADBEEF to addr 0x20 -> single WRITE cycle (no READ); DMEM[8]=0xDEADBEEF; reload returns the same value.
- With LSU_MISALIGN_TRAP_EN, LW at 0x22 -> resp_err=1 after 1 cycle, dmem_ena never high. Without the macro, the same request reads DMEM[8] with resp_err=0.
- Assert rst during the WRITE cycle of SH 0xFFFF to 0x30 (DMEM[12]=0) -> dmem_W drops immediately, DMEM[12] stays 0, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// Load/store unit driving the DMEM port: byte/half/word loads with extension, sub-word stores by read-modify-write.
// Optional misalignment/illegal-size trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_dmem_master #(
    parameter int ADDR_W = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_ena,
    output logic        dmem_R,
    output logic        dmem_W,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_in_data,
    input  logic [31:0] dmem_out_data,
    output logic [1:0]  dbg_state
);

    // Handshake: a request transfers on the posedge where req_valid && req_ready;
    // req_ready is high only in IDLE, resp_valid is a single-cycle pulse in RESP.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W+1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       rd_buf;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              req_err;
    logic [1:0]        eff_size;
    logic [ADDR_W+1:0] eff_addr;
    logic              unused_addr_hi;

    // Address bits above the word index never reach DMEM.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                            input logic uns, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] v;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   v = {{24{~uns & b[7]}}, b};
            2'b01:   v = {{16{~uns & h[15]}}, h};
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] rd, input logic [31:0] wd,
                                          input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] m;
        m = rd;
        case (size)
            2'b00:   m[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01:   m[{lane[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    always_comb begin
        req_err  = 1'b0;
        eff_size = req_size;
        eff_addr = req_addr[ADDR_W+1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
        // Without trapping, illegal size acts as word and low address bits are dropped.
        if (req_size == 2'b11) eff_size = 2'b10;
        if (eff_size == 2'b01) eff_addr[0] = 1'b0;
        if (eff_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err)           state_nxt = S_RESP;
                    else if (!req_we)      state_nxt = S_READ;
                    else if (eff_size[1])  state_nxt = S_WRITE;
                    else                   state_nxt = S_READ;
                end
            end
            S_READ:  state_nxt = r_we ? S_WRITE : S_RESP;
            S_WRITE: state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = (state == S_IDLE);
        resp_valid   = (state == S_RESP);
        dmem_ena     = 1'b0;
        dmem_R       = 1'b0;
        dmem_W       = 1'b0;
        dmem_addr    = 32'd0;
        dmem_in_data = 32'd0;
        case (state)
            S_READ: begin
                dmem_ena  = 1'b1;
                dmem_R    = 1'b1;
                dmem_addr = {{(32-ADDR_W){1'b0}}, r_addr[ADDR_W+1:2]};
            end
            S_WRITE: begin
                dmem_ena     = 1'b1;
                dmem_W       = 1'b1;
                dmem_addr    = {{(32-ADDR_W){1'b0}}, r_addr[ADDR_W+1:2]};
                dmem_in_data = merge(rd_buf, r_wdata, r_size, r_addr[1:0]);
            end
            default: ;
        endcase
    end

    // Request capture, read buffer and registered response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            rd_buf       <= 32'd0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                r_we         <= req_we;
                r_size       <= eff_size;
                r_unsigned   <= req_unsigned;
                r_addr       <= eff_addr;
                r_wdata      <= req_wdata;
                resp_rdata_q <= 32'd0;
                resp_err_q   <= req_err;
            end
            if (state == S_READ) begin
                rd_buf <= dmem_out_data;
                if (!r_we) resp_rdata_q <= extract(dmem_out_data, r_size, r_unsigned, r_addr[1:0]);
            end
        end
    end

    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign dbg_state  = state;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: directed test-plan steps plus random requests checked
// against a byte-level memory model; honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        dmem_ena, dmem_R, dmem_W;
    logic [31:0] dmem_addr, dmem_in_data, dmem_out_data;
    logic [1:0]  dbg_state;

    logic [31:0] mem     [0:2047];
    logic [31:0] ref_mem [0:2047];
    logic        bk_we;
    logic [10:0] bk_idx;
    logic [31:0] bk_data;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_dmem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .dmem_ena(dmem_ena), .dmem_R(dmem_R), .dmem_W(dmem_W),
        .dmem_addr(dmem_addr), .dmem_in_data(dmem_in_data),
        .dmem_out_data(dmem_out_data), .dbg_state(dbg_state)
    );

    // DMEM: asynchronous read, write on posedge; the back door preloads words.
    assign dmem_out_data = mem[dmem_addr[10:0]];
    always @(posedge clk) begin
        if (dmem_ena && dmem_W) mem[dmem_addr[10:0]] <= dmem_in_data;
        else if (bk_we)         mem[bk_idx] <= bk_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        bk_we   = 1'b1;
        bk_idx  = idx[10:0];
        bk_data = data;
        ref_mem[idx] = data;
        @(posedge clk);
        @(negedge clk);
        bk_we = 1'b0;
    endtask

    // Reference: access size in bytes, byte offset inside the word, and the trap decision.
    task automatic model_norm(input logic [1:0] size, input logic [31:0] addr,
                              output int nb, output int off, output bit err);
        err = 1'b0;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        if (size == 2'd3 || (off % nb) != 0) err = 1'b1;
`endif
        off = (off / nb) * nb;
    endtask

    // Issue one request from a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                          output logic [31:0] rdata, output logic rerr);
        int nb, off, idx, exp_lat, exp_reads, exp_writes, lat, n_ena, n_rd, n_wr;
        bit err;
        logic [31:0] w, v, mask, exp_rdata;
        model_norm(size, addr, nb, off, err);
        idx = int'(addr[12:2]);
        w = ref_mem[idx];
        exp_rdata = 32'd0;
        if (!err && !we) begin
            v = w >> (8 * off);
            if (nb < 4) begin
                mask = (32'd1 << (8 * nb)) - 32'd1;
                v = v & mask;
                if (!uns && v[8*nb-1]) v = v | ~mask;
            end
            exp_rdata = v;
        end
        if (!err && we) begin
            for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wdata[8*i +: 8];
            ref_mem[idx] = w;
        end
        exp_lat    = err ? 1 : (!we ? 2 : (nb == 4 ? 2 : 3));
        exp_reads  = (!err && (!we || nb < 4)) ? 1 : 0;
        exp_writes = (!err && we) ? 1 : 0;

        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        check({tag, " ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        lat = 0; n_ena = 0; n_rd = 0; n_wr = 0;
        rdata = 32'hx; rerr = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (dmem_ena) n_ena++;
            if (dmem_R) begin
                n_rd++;
                check({tag, " rd addr"}, dmem_addr, 32'(idx));
            end
            if (dmem_W) begin
                n_wr++;
                check({tag, " wr addr"}, dmem_addr, 32'(idx));
                check({tag, " wr data"}, dmem_in_data, w);
            end
            if (resp_valid) begin
                lat = k;
                rdata = resp_rdata;
                rerr = resp_err;
                check({tag, " resp ena"}, {31'd0, dmem_ena}, 32'd0);
                break;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rdata"}, rdata, exp_rdata);
        check({tag, " err"}, {31'd0, rerr}, {31'd0, err});
        check({tag, " reads"}, 32'(n_rd), 32'(exp_reads));
        check({tag, " writes"}, 32'(n_wr), 32'(exp_writes));
        check({tag, " ena cycles"}, 32'(n_ena), 32'(exp_reads + exp_writes));
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; bk_we = 1'b0; bk_idx = 11'd0; bk_data = 32'd0;
        repeat (3) @(negedge clk);
        check("rst ready", {31'd0, req_ready}, 32'd1);
        check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst err", {31'd0, resp_err}, 32'd0);
        check("rst dmem ctl", {29'd0, dmem_ena, dmem_R, dmem_W}, 32'd0);
        check("rst dmem addr", dmem_addr, 32'd0);
        check("rst dmem data", dmem_in_data, 32'd0);
        check("rst state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 64; i++) poke(i, $urandom);

        poke(4, 32'h8899AABB);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'd0, "LB 0x11", r, e);
        check("LB 0x11 value", r, 32'hFFFFFFAA);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'd0, "LBU 0x11", r, e);
        check("LBU 0x11 value", r, 32'h000000AA);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'd0, "LH 0x12", r, e);
        check("LH 0x12 value", r, 32'hFFFF8899);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, "LW 0x10", r, e);
        check("LW 0x10 value", r, 32'h8899AABB);

        poke(4, 32'h11223344);
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000005A, "SB 0x13", r, e);
        check("SB 0x13 mem", mem[4], 32'h5A223344);

        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, "SW 0x20", r, e);
        check("SW 0x20 mem", mem[8], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'd0, "LW 0x20", r, e);
        check("LW 0x20 value", r, 32'hDEADBEEF);

        do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'd0, "LW 0x22", r, e);
`ifdef LSU_MISALIGN_TRAP_EN
        check("LW 0x22 trap", {31'd0, e}, 32'd1);
`else
        check("LW 0x22 value", r, 32'hDEADBEEF);
        check("LW 0x22 no err", {31'd0, e}, 32'd0);
`endif

        // Reset lands in the WRITE cycle of a half store; nothing may commit or respond.
        poke(12, 32'd0);
        req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 32'h30;
        req_wdata = 32'h0000FFFF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort pre W", {31'd0, dmem_W}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort W drop", {31'd0, dmem_W}, 32'd0);
        check("abort ena drop", {31'd0, dmem_ena}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort mem", mem[12], 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("abort no resp", {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end
        check("abort ready", {31'd0, req_ready}, 32'd1);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 255)) | (32'($urandom_range(0, 3)) << 13);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, "rand", r, e);
        end
        for (int i = 0; i < 64; i++) check("final mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
